exe_stage: RTL

//   Execute pipeline stage between decode (ID) and memory (MEM). Holds one

---
 rtl/exe_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage: valid-qualified register of the decoded instruction, operand
// select, ALU, and valid/allowin handshake toward MEM plus a forwarding tap.

module alu (
    input  logic [13:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] or_res;
    logic [31:0] sel_res;

    assign add_res = alu_src1 + alu_src2;
    assign sub_res = alu_src1 + ~alu_src2 + 32'd1;
    assign or_res  = alu_src1 | alu_src2;

    // Unimplemented op bits select nothing, so they contribute a zero result.
    assign sel_res = ({32{alu_op[0]}} & add_res)
                   | ({32{alu_op[1]}} & alu_src1)
                   | ({32{alu_op[2]}} & or_res)
                   | ({32{alu_op[3]}} & sub_res);

    assign alu_result = (|alu_op) ? sel_res : 32'd0;
endmodule

module exe_stage #(
    parameter logic [31:0] PC_RST = 32'h1c000000,
    parameter int          DEST_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ds_to_es_valid,
    output logic              es_allowin,
    input  logic [31:0]       ds_pc,
    input  logic [13:0]       ds_alu_op,
    input  logic [31:0]       ds_rj_value,
    input  logic [31:0]       ds_rkd_value,
    input  logic [31:0]       ds_imm,
    input  logic              ds_src1_is_pc,
    input  logic              ds_src2_is_imm,
    input  logic [DEST_W-1:0] ds_dest,
    input  logic              ds_gr_we,
    input  logic              ms_allowin,
    output logic              es_to_ms_valid,
    output logic [31:0]       es_pc,
    output logic [31:0]       es_alu_result,
    output logic [DEST_W-1:0] es_dest,
    output logic              es_gr_we,
    output logic              es_fwd_valid,
    output logic [DEST_W-1:0] es_fwd_dest,
    output logic [31:0]       es_fwd_data
);
    logic              es_valid;
    logic              es_ready_go;
    logic [31:0]       pc_r;
    logic [13:0]       alu_op_r;
    logic [31:0]       rj_r;
    logic [31:0]       rkd_r;
    logic [31:0]       imm_r;
    logic              src1_is_pc_r;
    logic              src2_is_imm_r;
    logic [DEST_W-1:0] dest_r;
    logic              gr_we_r;
    logic [31:0]       alu_src1;
    logic [31:0]       alu_src2;

    assign es_ready_go = 1'b1;
    assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);

    // rst beats flush beats accept; a flushed cycle also drops the offered instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            es_valid      <= 1'b0;
            pc_r          <= PC_RST;
            alu_op_r      <= '0;
            rj_r          <= '0;
            rkd_r         <= '0;
            imm_r         <= '0;
            src1_is_pc_r  <= 1'b0;
            src2_is_imm_r <= 1'b0;
            dest_r        <= '0;
            gr_we_r       <= 1'b0;
        end else if (flush) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds_to_es_valid;
            if (ds_to_es_valid) begin
                pc_r          <= ds_pc;
                alu_op_r      <= ds_alu_op;
                rj_r          <= ds_rj_value;
                rkd_r         <= ds_rkd_value;
                imm_r         <= ds_imm;
                src1_is_pc_r  <= ds_src1_is_pc;
                src2_is_imm_r <= ds_src2_is_imm;
                dest_r        <= ds_dest;
                gr_we_r       <= ds_gr_we;
            end
        end
    end

    assign alu_src1 = src1_is_pc_r  ? pc_r  : rj_r;
    assign alu_src2 = src2_is_imm_r ? imm_r : rkd_r;

    alu u_alu (
        .alu_op     (alu_op_r),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_result (es_alu_result)
    );

    assign es_to_ms_valid = es_valid & es_ready_go & ~flush;
    assign es_pc          = pc_r;
    assign es_dest        = dest_r;
    assign es_gr_we       = es_valid & gr_we_r;
    assign es_fwd_valid   = es_valid & gr_we_r & (dest_r != '0);
    assign es_fwd_dest    = dest_r;
    assign es_fwd_data    = es_alu_result;
endmodule
